// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the device over
// the shared open-drain PS/2 clock/data lines. It sits beside the keyboard
// receive path, which must ignore line activity while busy is high.
//
// State table:
//   IDLE    | lines released, waiting for tx_valid
//   INHIBIT | clock held low for INHIBIT_CYCLES
//   START   | clock and data low for one cycle (start bit)
//   SHIFT   | clock released; data bits, parity and stop driven on device falling edges
//   ACK     | waiting for the device ack on the 11th falling edge
//   RELEASE | waiting for both lines to return high
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   ps2_clk, ps2_data     line levels at the pins (asynchronous)
//   ps2_clk_oe            1 = pull PS/2 clock low
//   ps2_data_oe           1 = pull PS/2 data low
//   tx_data, tx_valid     byte to send and send request
//   tx_ready              high only in IDLE
//   tx_done, tx_err       one-cycle completion / failure pulses
//   busy                  high in every state except IDLE
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fe;

  // Two-stage synchronizers; idle level of both lines is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          // {stop, odd parity, data}; shifted out LSB first
          shreg_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        bitcnt_d  = '0;
        tcnt_d    = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fe) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[9:1]};
          bitcnt_d  = bitcnt_q + 1'b1;
          // the 10th edge has just presented the stop bit
          if (bitcnt_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fe) begin
          if (!dat_s2_q) begin
            state_d = ST_RELEASE;
          end else begin
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_RELEASE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Timeout overrides any sub-state decision, including a same-cycle done.
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_RELEASE) &&
        tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

endmodule
